// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: default payload width and
// occupancy state encoding.
package pipe_pkg;
    localparam int unsigned PIPE_W = 32;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_ONE   = 2'd1;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd2;
endpackage

// File: rtl/pipe_dreg.sv
// WIDTH-bit data register with load enable and synchronous clear to RESET_VAL.
module pipe_dreg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = PIPE_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and synchronous flush.
// Optional stall-cycle counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = PIPE_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);
    logic [ST_W-1:0]  state_q, state_d;
    logic             acc, drn, clr;
    logic             main_en, main_sel_skid, skid_en;
    logic [WIDTH-1:0] main_din, skid_q;

    assign clr = reset | flush;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_en       = 1'b0;
        main_sel_skid = 1'b0;
        skid_en       = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_ONE;
                    main_en = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && drn) begin
                    main_en = 1'b1;
                end else if (acc) begin
                    state_d = ST_FULL;
                    skid_en = 1'b1;
                end else if (drn) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drn) begin
                    state_d       = ST_ONE;
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // in_ready comes from registered state and flush only: no out_ready path.
    always_comb begin
        out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
        in_ready  = (state_q != ST_FULL) && !flush;
        acc       = in_valid && in_ready;
        drn       = out_valid && out_ready;
    end

    assign main_din = main_sel_skid ? skid_q : in_data;

    pipe_dreg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk   (clk),
        .clr_i (clr),
        .en_i  (main_en),
        .d_i   (main_din),
        .q_o   (out_data)
    );

    pipe_dreg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk   (clk),
        .clr_i (clr),
        .en_i  (skid_en),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Cleared only by reset; flush leaves the count intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (out_valid && !out_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized
// traffic against a queue-based occupancy model.
module tb_pipe_stage_reg;
    localparam logic [31:0] RST_VAL = 32'h0;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RST_VAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [31:0] mq[$];
    logic [31:0] head = RST_VAL;
    logic [31:0] exp_stall = 32'd0;
    bit          known = 1'b0;
    bit          last_acc = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic        s_valid, s_ready;
    logic [31:0] s_data, s_stall;
    logic [31:0] drained[$];
    int          drain_cyc[$];
    int          cycle = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One clock: drive at negedge, sample, compare with the model, advance model.
    task automatic cyc(input logic rst_v, input logic fl_v, input logic iv_v,
                       input logic [31:0] d_v, input logic ordy_v);
        logic e_valid, e_ready;
        @(negedge clk);
        reset     = rst_v;
        flush     = fl_v;
        in_valid  = iv_v;
        in_data   = d_v;
        out_ready = ordy_v;
        #1;
        s_valid = out_valid;
        s_ready = in_ready;
        s_data  = out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
        s_stall = stall_cnt;
`else
        s_stall = exp_stall;
`endif
        e_valid = (mq.size() > 0);
        e_ready = (mq.size() < 2) && !fl_v;
        if (known) begin
            check("out_valid", 32'(s_valid), 32'(e_valid));
            check("in_ready", 32'(s_ready), 32'(e_ready));
            check("out_data", s_data, head);
            if (prev_hold) check("stall_stable", s_data, prev_data);
`ifdef PIPE_STAGE_STALL_CNT_EN
            check("stall_cnt", s_stall, exp_stall);
`endif
            if (s_valid && ordy_v) begin
                drained.push_back(s_data);
                drain_cyc.push_back(cycle);
            end
        end
        last_acc  = iv_v && e_ready;
        prev_hold = known && !rst_v && !fl_v && s_valid && !ordy_v;
        prev_data = s_data;
        if (rst_v) exp_stall = 32'd0;
        else if (e_valid && !ordy_v) exp_stall = exp_stall + 32'd1;
        if (rst_v || fl_v) begin
            mq.delete();
            head = RST_VAL;
        end else begin
            if (e_valid && ordy_v) void'(mq.pop_front());
            if (last_acc) mq.push_back(d_v);
            if (mq.size() > 0) head = mq[0];
        end
        if (rst_v) known = 1'b1;
        cycle++;
    endtask

    initial begin
        logic        r_iv;
        logic [31:0] r_d;
        bit          seen55;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset then first transaction latency
        cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'hA5A5A5A5, 0);
        check("rst_out_valid", 32'(s_valid), 32'd0);
        check("rst_out_data", s_data, RST_VAL);
        check("rst_in_ready", 32'(s_ready), 32'd1);
        cyc(0, 0, 0, 32'h0, 1);
        check("lat_valid", 32'(s_valid), 32'd1);
        check("lat_data", s_data, 32'hA5A5A5A5);
        check("lat_ready", 32'(s_ready), 32'd1);

        // Back-to-back streaming
        drained.delete(); drain_cyc.delete();
        for (int i = 1; i <= 16; i++) cyc(0, 0, 1, 32'(i), 1);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        check("stream_count", 32'(drained.size()), 32'd16);
        for (int i = 0; i < drained.size() && i < 16; i++) begin
            check("stream_data", drained[i], 32'(i + 1));
            check("stream_gap", 32'(drain_cyc[i] - drain_cyc[0]), 32'(i));
        end

        // Skid fill and drain
        drained.delete();
        cyc(0, 0, 1, 32'h11, 0);
        cyc(0, 0, 1, 32'h22, 0);
        cyc(0, 0, 0, 32'h0, 0);
        check("full_ready", 32'(s_ready), 32'd0);
        check("full_data", s_data, 32'h11);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        check("skid_ready_back", 32'(s_ready), 32'd1);
        check("skid_second", s_data, 32'h22);
        cyc(0, 0, 0, 32'h0, 1);
        check("skid_count", 32'(drained.size()), 32'd2);
        if (drained.size() == 2) begin
            check("skid_first", drained[0], 32'h11);
            check("skid_order", drained[1], 32'h22);
        end

        // Flush while FULL with a concurrent offer
        drained.delete();
        cyc(0, 0, 1, 32'h33, 0);
        cyc(0, 0, 1, 32'h44, 0);
        cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 1, 1, 32'h55, 0);
        check("flush_ready", 32'(s_ready), 32'd0);
        cyc(0, 0, 0, 32'h0, 1);
        check("flush_valid", 32'(s_valid), 32'd0);
        check("flush_data", s_data, RST_VAL);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'h0, 1);
        seen55 = 1'b0;
        foreach (drained[i]) if (drained[i] == 32'h55) seen55 = 1'b1;
        check("flush_no55", 32'(seen55), 32'd0);
        check("flush_drains", 32'(drained.size()), 32'd0);

`ifdef PIPE_STAGE_STALL_CNT_EN
        // Stall counter: 7 stalls, flush keeps it, reset clears it
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h66, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 32'h0, 1);
        check("stall_pre_flush", s_stall, 32'd7);
        cyc(0, 0, 0, 32'h0, 1);
        check("stall_post_flush", s_stall, 32'd7);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0);
        check("stall_reset", s_stall, 32'd0);
`endif

        // Randomized traffic; pending input held stable until accepted
        r_iv = 1'b0; r_d = '0; last_acc = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!r_iv || last_acc) begin
                r_iv = 1'($urandom % 2);
                r_d  = $urandom;
            end
            cyc(0, 1'($urandom_range(0, 63) == 0), r_iv, r_d, 1'($urandom % 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
